// File: rtl/rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arb
// Description : Registered N:1 multiplexer with a built-in arbiter
//               (round-robin or fixed priority) and valid/ready handshakes
//               on every channel and on the single downstream port.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arb #(
  parameter  int N     = 4,             // number of input channels, N >= 2
  parameter  int W     = 8,             // data width per channel
  parameter  int MODE  = 0,             // 0 = round-robin, 1 = fixed priority
  localparam int SEL_W = $clog2(N)      // channel index width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel
);

  // Channel count widened by one bit so the wrap compare cannot overflow.
  localparam logic [SEL_W:0]   c_n_ext = (SEL_W+1)'(N);
  // Highest legal channel index; the round-robin pointer wraps after it.
  localparam logic [SEL_W-1:0] c_last  = SEL_W'(N-1);

  // Output register and round-robin pointer.
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_ptr;

  // Arbitration and handshake wires.
  logic [SEL_W-1:0] w_search_base;
  logic [SEL_W:0]   w_cand;
  logic             w_found;
  logic [SEL_W-1:0] w_gnt;
  logic [N-1:0]     w_gnt_oh;
  logic             w_can_load;
  logic             w_xfer;
  logic [W-1:0]     w_gnt_data;
  logic [SEL_W-1:0] w_ptr_nxt;

  // Fixed priority always searches from channel 0; round-robin from the
  // pointer. Tying the base to zero lets both modes share one search loop.
  assign w_search_base = (MODE == 1) ? '0 : r_ptr;

  // The output register may accept a new beat when it is empty or is being
  // drained in this same cycle. Held low during reset so no channel sees
  // in_ready while rst_n is asserted.
  assign w_can_load = rst_n & (~r_out_valid | out_ready);

  // Ascending search from the base with wrap N-1 -> 0; first requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, w_search_base} + (SEL_W+1)'(k);
      if (w_cand >= c_n_ext) begin
        w_cand = w_cand - c_n_ext;
      end
      if (!w_found && in_valid[w_cand[SEL_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_cand[SEL_W-1:0];
      end
    end
  end

  // One-hot view of the winning channel; all zero when nobody requests.
  always_comb begin
    w_gnt_oh        = '0;
    w_gnt_oh[w_gnt] = w_found;
  end

  assign in_ready   = w_gnt_oh & {N{w_can_load}};
  assign w_xfer     = w_found & w_can_load;
  assign w_gnt_data = in_data[int'(w_gnt)*W +: W];

  // Next pointer is the channel after the winner, wrapping at N-1.
  assign w_ptr_nxt  = (w_gnt == c_last) ? '0 : w_gnt + SEL_W'(1);

  // Output beat register: load on input transfer, clear valid on a pure
  // drain, otherwise hold (covers the stall case). Data and select are
  // retained after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_sel   <= w_gnt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: advances only on an accepted input beat; stays at
  // zero in fixed-priority mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if ((MODE == 0) && w_xfer) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arb
// Description : Scoreboard bench for rr_mux_arb: round-robin N=4 instance,
//               fixed-priority N=4 instance and a 2:1 single-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arb;

  logic clk = 1'b0;
  logic rst_n;

  // Round-robin instance (N=4, W=8, MODE=0)
  logic [31:0] rr_in_data;
  logic [3:0]  rr_in_valid, rr_in_ready;
  logic [7:0]  rr_out_data;
  logic        rr_out_valid, rr_out_ready;
  logic [1:0]  rr_out_sel;

  // Fixed-priority instance (N=4, W=8, MODE=1)
  logic [31:0] fp_in_data;
  logic [3:0]  fp_in_valid, fp_in_ready;
  logic [7:0]  fp_out_data;
  logic        fp_out_valid, fp_out_ready;
  logic [1:0]  fp_out_sel;

  // Legacy 2:1 instance (N=2, W=1, MODE=0)
  logic [1:0]  n2_in_data, n2_in_valid, n2_in_ready;
  logic        n2_out_data, n2_out_valid, n2_out_ready, n2_out_sel;

  int n_checks = 0;
  int n_errors = 0;

  // Expected beats, packed as {sel[7:0], data[7:0]}
  logic [15:0] q_rr[$];
  logic [15:0] q_fp[$];
  logic [15:0] q_n2[$];
  logic [15:0] e_rr, e_fp, e_n2;

  logic [7:0] dat  [4];
  logic [7:0] datf [4];

  rr_mux_arb #(.N(4), .W(8), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data(rr_in_data), .in_valid(rr_in_valid), .in_ready(rr_in_ready),
    .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(rr_out_ready),
    .out_sel(rr_out_sel)
  );

  rr_mux_arb #(.N(4), .W(8), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in_data(fp_in_data), .in_valid(fp_in_valid), .in_ready(fp_in_ready),
    .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(fp_out_ready),
    .out_sel(fp_out_sel)
  );

  rr_mux_arb #(.N(2), .W(1), .MODE(0)) u_n2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(n2_in_data), .in_valid(n2_in_valid), .in_ready(n2_in_ready),
    .out_data(n2_out_data), .out_valid(n2_out_valid), .out_ready(n2_out_ready),
    .out_sel(n2_out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int sel, input logic [7:0] d);
    return {8'(sel), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare every accepted output beat against the scoreboard
  always @(negedge clk) begin
    if (rst_n && rr_out_valid && rr_out_ready) begin
      if (q_rr.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rr_unexpected_beat: got sel=%0d data=%0h, required no beat", rr_out_sel, rr_out_data);
      end else begin
        e_rr = q_rr.pop_front();
        check("rr_beat_sel",  32'(rr_out_sel),  32'(e_rr[15:8]));
        check("rr_beat_data", 32'(rr_out_data), 32'(e_rr[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && fp_out_valid && fp_out_ready) begin
      if (q_fp.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL fp_unexpected_beat: got sel=%0d data=%0h, required no beat", fp_out_sel, fp_out_data);
      end else begin
        e_fp = q_fp.pop_front();
        check("fp_beat_sel",  32'(fp_out_sel),  32'(e_fp[15:8]));
        check("fp_beat_data", 32'(fp_out_data), 32'(e_fp[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && n2_out_valid && n2_out_ready) begin
      if (q_n2.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL n2_unexpected_beat: got sel=%0d data=%0h, required no beat", n2_out_sel, n2_out_data);
      end else begin
        e_n2 = q_n2.pop_front();
        check("n2_beat_sel",  32'(n2_out_sel),  32'(e_n2[15:8]));
        check("n2_beat_data", 32'(n2_out_data), 32'(e_n2[7:0]));
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int seq_a[6];
    int seq_b[6];
    logic [2:0] cb;

    seq_a = '{3, 0, 1, 2, 3, 0};
    seq_b = '{0, 1, 2, 3, 0, 1};
    dat   = '{8'h11, 8'h22, 8'hA5, 8'h44};
    datf  = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};

    rst_n        = 1'b0;
    rr_in_data   = {dat[3], dat[2], dat[1], dat[0]};
    rr_in_valid  = 4'b1111;
    rr_out_ready = 1'b0;
    fp_in_data   = {datf[3], datf[2], datf[1], datf[0]};
    fp_in_valid  = 4'b1111;
    fp_out_ready = 1'b1;
    n2_in_data   = 2'b00;
    n2_in_valid  = 2'b11;
    n2_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rr_out_valid", 32'(rr_out_valid), 32'd0);
    check("rst_rr_out_data",  32'(rr_out_data),  32'd0);
    check("rst_rr_out_sel",   32'(rr_out_sel),   32'd0);
    check("rst_rr_in_ready",  32'(rr_in_ready),  32'd0);
    check("rst_fp_in_ready",  32'(fp_in_ready),  32'd0);
    check("rst_n2_out_valid", 32'(n2_out_valid), 32'd0);
    rr_in_valid  = 4'b0000;
    fp_in_valid  = 4'b0000;
    n2_in_valid  = 2'b00;
    rr_out_ready = 1'b1;
    rst_n        = 1'b1;
    tick();

    // Single channel: channel 2 with A5
    rr_in_valid = 4'b0100;
    #1 check("single_in_ready", 32'(rr_in_ready), 32'h4);
    q_rr.push_back(mk(2, 8'hA5));
    tick();
    rr_in_valid = 4'b0000;
    #1;
    check("single_out_valid", 32'(rr_out_valid), 32'd1);
    check("single_out_sel",   32'(rr_out_sel),   32'd2);
    check("single_out_data",  32'(rr_out_data),  32'hA5);
    check("single_in_ready_idle", 32'(rr_in_ready), 32'd0);
    tick();

    // Round-robin from pointer 3 (advanced past channel 2 above)
    rr_in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_wrap_in_ready", 32'(rr_in_ready), 32'(4'b0001 << seq_a[i]));
      q_rr.push_back(mk(seq_a[i], dat[seq_a[i]]));
      tick();
    end
    rr_in_valid = 4'b0000;
    tick();

    // Backpressure: pointer is 1; hold channel 1's beat for 3 stalled cycles
    rr_in_valid = 4'b1111;
    #1 check("bp_first_in_ready", 32'(rr_in_ready), 32'h2);
    q_rr.push_back(mk(1, dat[1]));
    tick();
    rr_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_valid",    32'(rr_out_valid), 32'd1);
      check("bp_stall_sel",      32'(rr_out_sel),   32'd1);
      check("bp_stall_data",     32'(rr_out_data),  32'(dat[1]));
      check("bp_stall_in_ready", 32'(rr_in_ready),  32'd0);
      tick();
    end
    rr_out_ready = 1'b1;
    #1 check("bp_resume_in_ready", 32'(rr_in_ready), 32'h4);
    q_rr.push_back(mk(2, dat[2]));
    tick();
    rr_in_valid = 4'b0000;
    #1;
    check("bp_no_bubble_valid", 32'(rr_out_valid), 32'd1);
    check("bp_no_bubble_sel",   32'(rr_out_sel),   32'd2);
    tick();

    // Reset mid-operation with a held beat (pointer is 3, only ch0 requests)
    rr_out_ready = 1'b0;
    rr_in_valid  = 4'b0001;
    #1 check("mid_in_ready", 32'(rr_in_ready), 32'h1);
    tick();
    rr_in_valid = 4'b1111;
    #1;
    check("mid_held_valid", 32'(rr_out_valid), 32'd1);
    check("mid_held_sel",   32'(rr_out_sel),   32'd0);
    check("mid_held_data",  32'(rr_out_data),  32'(dat[0]));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(rr_out_valid), 32'd0);
    check("mid_rst_out_data",  32'(rr_out_data),  32'd0);
    check("mid_rst_out_sel",   32'(rr_out_sel),   32'd0);
    check("mid_rst_in_ready",  32'(rr_in_ready),  32'd0);
    rr_in_valid  = 4'b0000;
    rr_out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Round-robin fairness from a fresh pointer
    rr_in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_fair_in_ready", 32'(rr_in_ready), 32'(4'b0001 << seq_b[i]));
      q_rr.push_back(mk(seq_b[i], dat[seq_b[i]]));
      tick();
    end
    rr_in_valid = 4'b0000;
    tick();

    // Fixed priority: channel 1 always beats channel 3
    fp_in_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      #1 check("fp_1010_in_ready", 32'(fp_in_ready), 32'h2);
      q_fp.push_back(mk(1, datf[1]));
      tick();
    end
    fp_in_valid = 4'b1000;
    #1 check("fp_1000_in_ready", 32'(fp_in_ready), 32'h8);
    q_fp.push_back(mk(3, datf[3]));
    tick();
    fp_in_valid = 4'b1100;
    #1 check("fp_1100_in_ready", 32'(fp_in_ready), 32'h4);
    q_fp.push_back(mk(2, datf[2]));
    tick();
    fp_in_valid = 4'b1111;
    #1 check("fp_1111_in_ready", 32'(fp_in_ready), 32'h1);
    q_fp.push_back(mk(0, datf[0]));
    tick();
    fp_in_valid = 4'b0000;
    tick();

    // Legacy 2:1 sweep over {data1, data0, valid}
    for (int c = 0; c < 8; c++) begin
      cb          = 3'(c);
      n2_in_data  = cb[2:1];
      n2_in_valid = cb[0] ? 2'b10 : 2'b01;
      #1 check("n2_in_ready", 32'(n2_in_ready), cb[0] ? 32'h2 : 32'h1);
      q_n2.push_back(mk(cb[0] ? 1 : 0, cb[0] ? {7'd0, cb[2]} : {7'd0, cb[1]}));
      tick();
    end
    n2_in_valid = 2'b00;
    tick();

    // Let the monitors consume any remaining beats (bounded)
    for (int i = 0; i < 20; i++) begin
      if (q_rr.size() == 0 && q_fp.size() == 0 && q_n2.size() == 0) break;
      tick();
    end
    check("rr_queue_empty", 32'(q_rr.size()), 32'd0);
    check("fp_queue_empty", 32'(q_fp.size()), 32'd0);
    check("n2_queue_empty", 32'(q_n2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
